// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: funct codes,
// FSM state encodings and the recognised-request decode.
package mips_muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // The eight HI/LO functs occupy 0100xx and 0110xx.
  function automatic logic is_recognised(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage request/response bundle for the HI/LO sequencer.
interface muldiv_ctrl_if #(parameter int DATA_W = 32);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, funct, rs_data, rt_data, flush,
    input  stall, busy, done, rd_data, hi, lo
  );

  modport slave (
    input  start, funct, rs_data, rt_data, flush,
    output stall, busy, done, rd_data, hi, lo
  );
endinterface

// File: rtl/muldiv_step_dp.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// on a 2*DATA_W accumulator ({upper, lower}).
module muldiv_step_dp #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*DATA_W-1:DATA_W]};
    if (acc[0]) begin
      sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
    end
    // Remainder shifted left with the next dividend bit; the borrow bit of
    // the trial subtraction decides the quotient bit.
    rem_sh = acc[2*DATA_W-1:DATA_W-1];
    diff   = rem_sh - {1'b0, opnd};

    if (is_div) begin
      if (!diff[DATA_W]) begin
        acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: accepts EX-stage requests, runs 32
// iterations on unsigned magnitudes, then applies sign fixup into HI/LO.
module muldiv_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 5
) (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave bus
);

  logic [1:0]          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   opnd_reg;
  logic                is_div_reg;
  logic                neg_res_reg;
  logic                neg_rem_reg;
  logic                div0_reg;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;

  logic                idle;
  logic                accept;
  logic                is_md;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] step_acc;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  assign idle   = (state_reg == ST_IDLE);
  assign accept = idle & bus.start & ~bus.flush;
  assign is_md  = (bus.funct[5:2] == 4'b0110);

  // funct[0]==0 selects the signed variants (MULT, DIV).
  assign a_neg = ~bus.funct[0] & bus.rs_data[DATA_W-1];
  assign b_neg = ~bus.funct[0] & bus.rt_data[DATA_W-1];
  assign a_mag = a_neg ? -bus.rs_data : bus.rs_data;
  assign b_mag = b_neg ? -bus.rt_data : bus.rt_data;

  muldiv_step_dp #(.DATA_W(DATA_W)) u_step (
    .is_div  (is_div_reg),
    .acc     (acc_reg),
    .opnd    (opnd_reg),
    .acc_next(step_acc)
  );

  assign prod = neg_res_reg ? -acc_reg : acc_reg;
  assign quo  = div0_reg ? {DATA_W{1'b1}}
              : (neg_res_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0]);
  // Divide-by-zero leaves the dividend magnitude as remainder, so the
  // dividend-sign fixup restores the original rs value.
  assign rem  = neg_rem_reg ? -acc_reg[2*DATA_W-1:DATA_W] : acc_reg[2*DATA_W-1:DATA_W];

  assign bus.stall = bus.start & is_recognised(bus.funct) & ~idle;
  assign bus.busy  = ~idle;
  assign bus.done  = (state_reg == ST_FIX) & ~bus.flush;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

  always_comb begin
    bus.rd_data = '0;
    if (accept && bus.funct == F_MFHI) begin
      bus.rd_data = hi_reg;
    end else if (accept && bus.funct == F_MFLO) begin
      bus.rd_data = lo_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && is_md) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            is_div_reg  <= bus.funct[1];
            acc_reg     <= {{DATA_W{1'b0}}, (bus.funct[1] ? a_mag : b_mag)};
            opnd_reg    <= bus.funct[1] ? b_mag : a_mag;
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            div0_reg    <= (bus.rt_data == '0);
          end else if (accept && bus.funct == F_MTHI) begin
            hi_reg <= bus.rs_data;
          end else if (accept && bus.funct == F_MTLO) begin
            lo_reg <= bus.rs_data;
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
              state_reg <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state_reg <= ST_IDLE;
          if (!bus.flush) begin
            if (is_div_reg) begin
              hi_reg <= rem;
              lo_reg <= quo;
            end else begin
              hi_reg <= prod[2*DATA_W-1:DATA_W];
              lo_reg <= prod[DATA_W-1:0];
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic reference model compared every
// cycle, plus literal expectations for each directed scenario.
module tb_muldiv_ctrl;

  localparam logic [5:0] T_MFHI  = 6'b010000;
  localparam logic [5:0] T_MTHI  = 6'b010001;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_MTLO  = 6'b010011;
  localparam logic [5:0] T_MULT  = 6'b011000;
  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV   = 6'b011010;
  localparam logic [5:0] T_DIVU  = 6'b011011;
  localparam logic [5:0] T_ADD   = 6'b100000;
  localparam int OP_CYCLES = 33;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic check_en;

  muldiv_ctrl_if #(.DATA_W(32)) bus ();

  muldiv_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model_op(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint     sa, sb, sq, sr;
    logic [63:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (f)
      T_MULT:  begin w = 64'(sa * sb); rh = w[63:32]; rl = w[31:0]; end
      T_MULTU: begin w = 64'(a) * 64'(b); rh = w[63:32]; rl = w[31:0]; end
      T_DIV, T_DIVU: begin
        if (b == 0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else if (f == T_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          w  = 64'(sq); rl = w[31:0];
          w  = 64'(sr); rh = w[31:0];
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Model state: architectural HI/LO plus cycles left in an in-flight op.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  int          m_left;

  function automatic logic recog(input logic [5:0] f);
    return f inside {T_MFHI, T_MTHI, T_MFLO, T_MTLO, T_MULT, T_MULTU, T_DIV, T_DIVU};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left != 0) begin
      if (bus.flush) begin
        m_left = 0;
      end else if (m_left == 1) begin
        m_hi = m_res_hi; m_lo = m_res_lo; m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (bus.start && !bus.flush) begin
      if (bus.funct inside {T_MULT, T_MULTU, T_DIV, T_DIVU}) begin
        model_op(bus.funct, bus.rs_data, bus.rt_data, m_res_hi, m_res_lo);
        m_left = OP_CYCLES;
      end else if (bus.funct == T_MTHI) begin
        m_hi = bus.rs_data;
      end else if (bus.funct == T_MTLO) begin
        m_lo = bus.rs_data;
      end
    end
  end

  always @(negedge clk) begin
    logic busy_e, done_e, stall_e;
    logic [31:0] rd_e;
    if (check_en) begin
      busy_e  = (m_left != 0);
      done_e  = (m_left == 1) && !bus.flush;
      stall_e = bus.start && recog(bus.funct) && busy_e;
      rd_e    = '0;
      if (!busy_e && bus.start && !bus.flush) begin
        if (bus.funct == T_MFHI) rd_e = m_hi;
        else if (bus.funct == T_MFLO) rd_e = m_lo;
      end
      check("busy", 32'(bus.busy), 32'(busy_e));
      check("done", 32'(bus.done), 32'(done_e));
      check("stall", 32'(bus.stall), 32'(stall_e));
      check("rd_data", bus.rd_data, rd_e);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic drive(input logic st, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = st; bus.funct = f; bus.rs_data = a; bus.rt_data = b;
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    @(posedge clk); #1;
    drive(1'b1, f, a, b);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 60);
    check({name, "_latency"}, 32'(lat), 32'(OP_CYCLES));
    @(posedge clk); #1;
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
    $display("op %s rs=%h rt=%h -> hi=%h lo=%h latency=%0d", name, a, b, bus.hi, bus.lo, lat);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; check_en = 1'b0;
    rst = 1'b1; bus.flush = 1'b0;
    drive(1'b0, 6'd0, '0, '0);
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    $display("reset hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

    run_op("mult",   T_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu",  T_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",    T_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0",  T_DIVU,  32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div0n",  T_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divovf", T_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",   T_DIVU,  32'd100,        32'd7,         32'd2,         32'd14);

    // MULT then MFLO queued behind it
    @(posedge clk); #1;
    drive(1'b1, T_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(1'b1, T_MFLO, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      if (bus.stall) n++;
    end while (bus.stall && n < 60);
    check("mflo_stall_cycles", 32'(n), 32'(OP_CYCLES));
    check("mflo_rd", bus.rd_data, 32'h0000_000F);
    $display("mflo after mult stalled=%0d rd_data=%h", n, bus.rd_data);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);

    // flush a DIV while counter is 10
    @(posedge clk); #1;
    drive(1'b1, T_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_hi", bus.hi, 32'h0);
    check("flush_lo", bus.lo, 32'h0000_000F);
    $display("flush busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // reset during MULT
    @(posedge clk); #1;
    drive(1'b1, T_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    $display("reset mid-op busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // MTHI then MFHI
    @(posedge clk); #1;
    drive(1'b1, T_MTHI, 32'hDEAD_BEEF, '0);
    @(posedge clk); #1;
    drive(1'b1, T_MFHI, '0, '0);
    @(negedge clk);
    check("mfhi_rd", bus.rd_data, 32'hDEAD_BEEF);
    check("mfhi_stall", 32'(bus.stall), 32'h0);
    $display("mthi/mfhi rd_data=%h", bus.rd_data);

    // unrecognised funct
    @(posedge clk); #1;
    drive(1'b1, T_ADD, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    check("add_stall", 32'(bus.stall), 32'h0);
    check("add_rd", bus.rd_data, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);
    @(negedge clk);
    check("add_busy", 32'(bus.busy), 32'h0);
    check("add_hi", bus.hi, 32'hDEAD_BEEF);
    $display("add funct stall=%b busy=%b hi=%h", bus.stall, bus.busy, bus.hi);

    // MTLO under flush in IDLE is ignored
    @(posedge clk); #1;
    drive(1'b1, T_MTLO, 32'h0000_0055, '0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 6'd0, '0, '0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("mtlo_flush_lo", bus.lo, 32'h0);
    $display("mtlo under flush lo=%h", bus.lo);

    @(posedge clk); #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
